// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX register with EX/MEM and MEM/WB forwarding, ALU operand select, load-use bubble and flush
module id_ex_stage (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs_addr,
  input  logic [4:0]  id_rt_addr,
  input  logic [4:0]  id_rd_addr,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_shamt,
  input  logic [4:0]  id_ALUCtl,
  input  logic        id_Sign,
  input  logic        id_ALUSrc1,
  input  logic        id_ALUSrc2,
  input  logic        id_uses_rt,
  input  logic        id_RegWrite,
  input  logic        id_MemRead,
  input  logic        id_MemWrite,
  input  logic        flush,
  input  logic        hold,
  input  logic        exmem_RegWrite,
  input  logic [4:0]  exmem_rd_addr,
  input  logic [31:0] exmem_result,
  input  logic        memwb_RegWrite,
  input  logic [4:0]  memwb_rd_addr,
  input  logic [31:0] memwb_data,
  output logic [31:0] in1,
  output logic [31:0] in2,
  output logic [4:0]  ALUCtl,
  output logic        Sign,
  output logic [31:0] ex_store_data,
  output logic        ex_valid,
  output logic        ex_RegWrite,
  output logic        ex_MemRead,
  output logic        ex_MemWrite,
  output logic [4:0]  ex_rd_addr,
  output logic        id_stall
);
  typedef struct packed {
    logic        v;
    logic [4:0]  rs_a;
    logic [4:0]  rt_a;
    logic [4:0]  rd_a;
    logic [31:0] rs_d;
    logic [31:0] rt_d;
    logic [31:0] imm;
    logic [4:0]  shamt;
    logic [4:0]  alu;
    logic        sign;
    logic        src1;
    logic        src2;
    logic        rw;
    logic        mr;
    logic        mw;
  } stage_t;
  localparam stage_t bubble = '{alu: 5'h1f, default: '0};
  stage_t r, id_f, nxt;
  logic lu;
  logic [31:0] fwd_rs, fwd_rt;
  assign lu = r.v & r.mr & r.rw & (r.rd_a != 5'd0) & id_valid &
              ((id_rs_addr == r.rd_a) | (id_uses_rt & (id_rt_addr == r.rd_a)));
  assign id_f = '{v: id_valid, rs_a: id_rs_addr, rt_a: id_rt_addr, rd_a: id_rd_addr,
                  rs_d: id_rs_data, rt_d: id_rt_data, imm: id_imm, shamt: id_shamt,
                  alu: id_ALUCtl, sign: id_Sign, src1: id_ALUSrc1, src2: id_ALUSrc2,
                  rw: id_RegWrite, mr: id_MemRead, mw: id_MemWrite};
  assign nxt = flush ? bubble : hold ? r : lu ? bubble : id_f;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r <= bubble;
    else r <= nxt;
  assign fwd_rs = (r.rs_a == 5'd0) ? r.rs_d :
                  (exmem_RegWrite && exmem_rd_addr == r.rs_a) ? exmem_result :
                  (memwb_RegWrite && memwb_rd_addr == r.rs_a) ? memwb_data : r.rs_d;
  assign fwd_rt = (r.rt_a == 5'd0) ? r.rt_d :
                  (exmem_RegWrite && exmem_rd_addr == r.rt_a) ? exmem_result :
                  (memwb_RegWrite && memwb_rd_addr == r.rt_a) ? memwb_data : r.rt_d;
  assign in1 = r.src1 ? {27'b0, r.shamt} : fwd_rs;
  assign in2 = r.src2 ? r.imm : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ALUCtl = r.alu;
  assign Sign = r.sign;
  assign ex_valid = r.v;
  assign ex_RegWrite = r.rw;
  assign ex_MemRead = r.mr;
  assign ex_MemWrite = r.mw;
  assign ex_rd_addr = r.rd_a;
  assign id_stall = ~flush & (hold | lu);
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage with directed vectors
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt, id_ALUCtl;
  logic        id_Sign, id_ALUSrc1, id_ALUSrc2, id_uses_rt;
  logic        id_RegWrite, id_MemRead, id_MemWrite;
  logic        flush, hold;
  logic        exmem_RegWrite;
  logic [4:0]  exmem_rd_addr;
  logic [31:0] exmem_result;
  logic        memwb_RegWrite;
  logic [4:0]  memwb_rd_addr;
  logic [31:0] memwb_data;
  logic [31:0] in1, in2, ex_store_data;
  logic [4:0]  ALUCtl, ex_rd_addr;
  logic        Sign, ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, id_stall;
  typedef struct {
    string        n;
    logic [107:0] v;
  } item_t;
  item_t q[$];
  int passed = 0;
  int total = 0;
  logic [107:0] act;
  id_ex_stage dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_ALUCtl(id_ALUCtl), .id_Sign(id_Sign),
    .id_ALUSrc1(id_ALUSrc1), .id_ALUSrc2(id_ALUSrc2), .id_uses_rt(id_uses_rt),
    .id_RegWrite(id_RegWrite), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
    .flush(flush), .hold(hold),
    .exmem_RegWrite(exmem_RegWrite), .exmem_rd_addr(exmem_rd_addr), .exmem_result(exmem_result),
    .memwb_RegWrite(memwb_RegWrite), .memwb_rd_addr(memwb_rd_addr), .memwb_data(memwb_data),
    .in1(in1), .in2(in2), .ALUCtl(ALUCtl), .Sign(Sign), .ex_store_data(ex_store_data),
    .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_rd_addr(ex_rd_addr), .id_stall(id_stall)
  );
  always #5 clk = ~clk;
  assign act = {in1, in2, ex_store_data, ALUCtl, ex_valid, ex_rd_addr, id_stall};
  always @(negedge clk)
    if (q.size() != 0) begin
      item_t it;
      it = q.pop_front();
      total++;
      if (act === it.v) passed++;
      else $display("FAIL %s: got in1/in2/st/alu/v/rd/stall=%h required %h", it.n, act, it.v);
    end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input string n, input logic [31:0] a, b, s, input logic [4:0] alu,
                      input logic v, input logic [4:0] rd, input logic st);
    item_t it;
    it.n = n;
    it.v = {a, b, s, alu, v, rd, st};
    q.push_back(it);
  endtask
  task automatic drive_id(input logic v, input logic [4:0] rs, rt, rd, input logic [31:0] rsd, rtd, im,
                          input logic [4:0] sh, alu, input logic s1, s2, ur, rw, mr);
    id_valid = v; id_rs_addr = rs; id_rt_addr = rt; id_rd_addr = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = im; id_shamt = sh; id_ALUCtl = alu;
    id_ALUSrc1 = s1; id_ALUSrc2 = s2; id_uses_rt = ur; id_RegWrite = rw; id_MemRead = mr;
    id_Sign = 1'b0; id_MemWrite = 1'b0;
  endtask
  task automatic set_exmem(input logic w, input logic [4:0] a, input logic [31:0] d);
    exmem_RegWrite = w; exmem_rd_addr = a; exmem_result = d;
  endtask
  task automatic set_memwb(input logic w, input logic [4:0] a, input logic [31:0] d);
    memwb_RegWrite = w; memwb_rd_addr = a; memwb_data = d;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    reset_n = 1'b0; flush = 1'b0; hold = 1'b0;
    set_exmem(0, 0, 0); set_memwb(0, 0, 0);
    drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick;
    drive_id(1, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
             5'($urandom), 5'($urandom), 1, 1, 1, 1, 1);
    push("reset", 0, 0, 0, 5'h1f, 0, 0, 0);
    tick; hold = 1;
    push("reset_hold", 0, 0, 0, 5'h1f, 0, 0, 1);
    tick; hold = 0; reset_n = 1'b1;
    drive_id(1, 1, 2, 3, 5, 7, 0, 0, 5'b00010, 0, 0, 1, 1, 0);
    push("post_reset_bubble", 0, 0, 0, 5'h1f, 0, 0, 0);
    tick;
    drive_id(1, 3, 5, 6, 1, 32'h55, 0, 0, 5'd2, 0, 0, 1, 1, 0);
    push("add", 5, 7, 7, 5'd2, 1, 3, 0);
    tick; hold = 1;
    set_exmem(1, 3, 32'h10); set_memwb(1, 3, 32'h20);
    push("fwd_exmem_priority", 32'h10, 32'h55, 32'h55, 5'd2, 1, 6, 1);
    tick; exmem_RegWrite = 0;
    push("fwd_memwb", 32'h20, 32'h55, 32'h55, 5'd2, 1, 6, 1);
    tick; memwb_rd_addr = 5;
    push("fwd_rt_memwb", 1, 32'h20, 32'h20, 5'd2, 1, 6, 1);
    tick; hold = 0;
    drive_id(1, 0, 0, 7, 32'h77, 32'h88, 0, 0, 5'd2, 0, 0, 1, 1, 0);
    set_exmem(1, 0, 32'hAAAA); set_memwb(1, 0, 32'hBBBB);
    push("fwd_no_match", 1, 32'h55, 32'h55, 5'd2, 1, 6, 0);
    tick;
    drive_id(1, 1, 4, 4, 32'h100, 0, 8, 0, 5'd2, 0, 1, 0, 1, 1);
    push("fwd_r0_ignored", 32'h77, 32'h88, 32'h88, 5'd2, 1, 7, 0);
    tick;
    set_exmem(0, 0, 0); set_memwb(0, 0, 0);
    drive_id(1, 4, 2, 5, 0, 7, 0, 0, 5'd2, 0, 0, 1, 1, 0);
    push("lw_in_ex_stall", 32'h100, 8, 0, 5'd2, 1, 4, 1);
    tick;
    set_exmem(1, 4, 32'h108);
    push("lu_bubble", 0, 0, 0, 5'h1f, 0, 0, 0);
    tick;
    set_exmem(0, 0, 0); set_memwb(1, 4, 32'hDEAD);
    drive_id(1, 0, 2, 8, 0, 1, 0, 3, 5'b01000, 1, 0, 1, 1, 0);
    push("lu_fwd_memwb", 32'hDEAD, 7, 7, 5'd2, 1, 5, 0);
    tick;
    set_memwb(0, 0, 0);
    drive_id(1, 1, 9, 9, 2, 32'h1234, 32'hFFFFFFFF, 0, 5'd2, 0, 1, 0, 1, 0);
    push("sll_shamt", 3, 1, 1, 5'b01000, 1, 8, 0);
    tick;
    drive_id(1, 1, 10, 10, 32'h40, 0, 4, 0, 5'd2, 0, 1, 0, 1, 1);
    push("addi_imm", 2, 32'hFFFFFFFF, 32'h1234, 5'd2, 1, 9, 0);
    tick;
    drive_id(1, 10, 2, 11, 0, 32'h22, 0, 0, 5'd2, 0, 0, 1, 1, 0);
    flush = 1; hold = 1;
    push("flush_kills_stall", 32'h40, 4, 0, 5'd2, 1, 10, 0);
    tick; flush = 0; hold = 0;
    drive_id(1, 1, 2, 11, 32'h11, 32'h22, 0, 0, 5'd3, 0, 0, 1, 1, 0);
    push("flush_bubble", 0, 0, 0, 5'h1f, 0, 0, 0);
    tick; hold = 1;
    drive_id(1, 5, 6, 12, 32'h55, 32'h66, 0, 0, 5'd4, 0, 0, 1, 1, 0);
    push("hold1", 32'h11, 32'h22, 32'h22, 5'd3, 1, 11, 1);
    tick;
    drive_id(1, 7, 8, 13, 32'h77, 32'h88, 0, 0, 5'd5, 0, 0, 1, 1, 0);
    push("hold2", 32'h11, 32'h22, 32'h22, 5'd3, 1, 11, 1);
    tick;
    drive_id(1, 3, 4, 14, 32'h33, 32'h44, 0, 0, 5'd6, 0, 0, 1, 1, 0);
    push("hold3", 32'h11, 32'h22, 32'h22, 5'd3, 1, 11, 1);
    tick; hold = 0;
    push("hold_release", 32'h11, 32'h22, 32'h22, 5'd3, 1, 11, 0);
    tick;
    push("after_hold", 32'h33, 32'h44, 32'h44, 5'd6, 1, 14, 0);
    tick;
    tick;
    total++;
    if (q.size() == 0) passed++;
    else $display("FAIL queue_drain: %0d items left, required 0", q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
